// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump engine.
// Holds the FSM state encoding and the default geometry of the RV32I
// register file (register count, address width, data width).
package regdump_pkg;

   localparam int NUM_REGS_DFLT = 32;
   localparam int ADDR_W_DFLT   = 5;
   localparam int DATA_W_DFLT   = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      READ,
      SEND,
      CSUM,
      DONE
   } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Bus bundle between the dump engine and its surroundings:
//   read port : dump_req, dump_gnt, rd_addr, rd_data (register file side)
//   stream    : m_valid, m_ready, m_data, m_last    (debug transport side)
// Modport master is the dump engine, slave is the register file / transport.
interface regfile_dump_if
   import regdump_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) ();

   logic              dump_req;
   logic              dump_gnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output dump_req, rd_addr, m_valid, m_data, m_last,
      input  dump_gnt, rd_data, m_ready
   );

   modport slave (
      input  dump_req, rd_addr, m_valid, m_data, m_last,
      output dump_gnt, rd_data, m_ready
   );

endinterface

// File: rtl/regdump_csum.sv
// XOR accumulator for the optional dump checksum.
// Ports: clk, rst (sync, active-high), clear (sync clear), en (fold value
// into sum), value (word to fold), sum (running XOR).
module regdump_csum
   import regdump_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] sum
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum ^ value;
      end
   end

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine for the RV32I register file.
// On start it requests the register-file read port, reads registers
// 0..NUM_REGS-1 one at a time and streams each word out over valid/ready.
// Optional feature (macro REGDUMP_CHECKSUM_EN): append the XOR of all
// dumped words as a final extra word.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - one-cycle dump request, honoured only when idle
//   bus       - regfile_dump_if.master (read port + output stream)
//   busy      - dump in progress (any state except IDLE)
//   done      - one-cycle pulse after the final word is accepted
module regfile_dump
   import regdump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DFLT,
   parameter int ADDR_W   = ADDR_W_DFLT,
   parameter int DATA_W   = DATA_W_DFLT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   regfile_dump_if.master bus,
   output logic           busy,
   output logic           done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] data_q;
   logic              capture;
   logic              advance;
   logic              launch;

   assign launch = (state == IDLE) && start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      bus.dump_req = 1'b0;
      bus.m_valid  = 1'b0;
      bus.m_last   = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      capture      = 1'b0;
      advance      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = REQ;
         end
         REQ: begin
            bus.dump_req = 1'b1;
            if (bus.dump_gnt) state_next = READ;
         end
         READ: begin
            bus.dump_req = 1'b1;
            // Without grant the read port shows someone else's data: hold off.
            if (bus.dump_gnt) begin
               capture    = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            bus.dump_req = 1'b1;
            bus.m_valid  = 1'b1;
`ifndef REGDUMP_CHECKSUM_EN
            bus.m_last   = (index == LAST_IDX);
`endif
            if (bus.m_ready) begin
               if (index == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                  state_next = CSUM;
`else
                  state_next = DONE;
`endif
               end else begin
                  advance    = 1'b1;
                  state_next = READ;
               end
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         CSUM: begin
            bus.m_valid = 1'b1;
            bus.m_last  = 1'b1;
            if (bus.m_ready) state_next = DONE;
         end
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      bus.rd_addr = (state != IDLE) ? index : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index  <= '0;
         data_q <= '0;
      end else begin
         if (launch) begin
            index <= '0;
         end else if (advance) begin
            index <= index + 1'b1;
         end
         if (capture) begin
            data_q <= bus.rd_data;
         end
      end
   end

`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum;

   regdump_csum #(.DATA_W(DATA_W)) u_csum (
      .clk   (clk),
      .rst   (rst),
      .clear (launch),
      .en    (capture),
      .value (bus.rd_data),
      .sum   (csum)
   );

   assign bus.m_data = (state == CSUM) ? csum : data_q;
`else
   assign bus.m_data = data_q;
`endif

endmodule
